alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier controller.
- Owns no adder: every addition goes through the core's shared 32-bit ALU, which it drives with the ADD control code and whose Result and carry flag it consumes.
- Sits beside the ALU in the execute stage; the core stalls on busy and picks up the product on done.

Parameters:
- WIDTH, 32, operand width; must equal the ALU datapath width.
- ITER, 32, number of add/shift iterations; must equal WIDTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op_a  input  WIDTH  multiplier; latched on accepted start.
- op_b  input  WIDTH  multiplicand; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle in DONE.
- product_hi  output  WIDTH  upper half of the 64-bit product.
- product_lo  output  WIDTH  lower half of the 64-bit product.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_ctrl  output  3  ALU control code.
- alu_result  input  WIDTH  ALU Result, combinational from alu_a/alu_b/alu_ctrl.
- alu_c  input  1  ALU carry-out flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a clock edge):
  - state=IDLE; busy=0, done=0; product_hi=0, product_lo=0.
  - Internal hi, lo, mcand, carry and cnt all cleared.
  - Applies immediately even mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_a=0, alu_b=0, alu_ctrl=3'b000.
  - start=1 at an edge: lo<=op_a, mcand<=op_b, hi<=0, carry<=0, cnt<=0, go to RUN.
- RUN:
  - Drive alu_a=hi, alu_b=mcand, alu_ctrl=3'b000 (ADD), held constant for all of RUN.
  - Each edge, if lo[0]=1: {c,h} = {alu_c, alu_result}; else {c,h} = {0, hi}.
  - Update {carry,hi,lo} <= {0, c, h, lo} >> 1, i.e. hi<={c,h[WIDTH-1:1]} and lo<={h[0],lo[WIDTH-1:1]}. Register carry is always 0 after the shift.
  - cnt<=cnt+1. On the edge where cnt==ITER-1, go to DONE and load product_hi<=next hi, product_lo<=next lo.
  - start is ignored; operands are not re-latched.
- DONE:
  - done=1 for exactly this one cycle; ALU outputs as in IDLE.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise return to IDLE.
- Latency: start sampled at edge E0 -> busy high cycles E0..E0+32 -> DONE entered at edge E0+32 -> done high for one cycle. Product is valid from that edge.
- Throughput: one product per 33 cycles back-to-back.
- product_hi and product_lo hold their value until the next DONE entry or reset; they do not change during a subsequent RUN.
- Arithmetic:
  - Unsigned only. The full 64-bit result is exact; the carry from the ALU add is captured through alu_c, so there is no overflow.
  - The ALU V/N/Z flags are unused.
- busy and done are never high together. done is never high two cycles consecutively.
- op_a and op_b are don't-care except at the accepting edge.

Test Plan:
- 3 x 5: start with op_a=3, op_b=5 -> busy for 32 cycles; done on the 32nd edge after start; product_hi=0, product_lo=15; alu_ctrl=000 throughout RUN.
- 0xFFFFFFFF x 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001. This exercises alu_c capture every iteration.
- 0 x 0x12345678 and 0x80000000 x 2 -> products 0 and {0x00000001, 0x00000000}. In the first case alu_result is never consumed, since lo[0] is always 0.
- Reset mid-operation: start 7 x 9, drive rst=0 at RUN cycle 10 -> next cycle busy=0, done=0, product_hi=0, product_lo=0. No done appears within 40 cycles unless a new start is issued.
- start asserted every cycle during RUN with different operands -> those starts are ignored and the original product is returned. A start held high in the DONE cycle launches the next operation immediately, so done fires again exactly 33 cycles later.
- Hold: after a completed 6 x 7, leave start=0 for 50 cycles -> product_hi=0 and product_lo=42 remain stable; done stays 0.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier that borrows the
// core's shared ALU for every addition.
module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

    // Partial sum for this iteration before the right shift.
    logic             sum_c;
    logic [WIDTH-1:0] sum_h;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        sum_c     = 1'b0;
        sum_h     = '0;

        case (state_q)
            S_RUN: begin
                alu_a = hi_q;
                alu_b = mcand_q;
                // The carry register is always zero here, so the no-add path
                // is the plain {0, hi} pass-through.
                if (lo_q[0]) begin
                    sum_c = alu_c;
                    sum_h = alu_result;
                end else begin
                    sum_c = carry_q;
                    sum_h = hi_q;
                end
                hi_d    = {sum_c, sum_h[WIDTH-1:1]};
                lo_d    = {sum_h[0], lo_q[WIDTH-1:1]};
                carry_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d   = S_DONE;
                    prod_hi_d = hi_d;
                    prod_lo_d = lo_d;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    state_d = S_RUN;
                    lo_d    = op_a;
                    mcand_d = op_b;
                    hi_d    = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign product_hi = prod_hi_q;
    assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed plus randomized checks of alu_mul_seq against a 64-bit product
// model, with a stand-in ALU wired to the multiplier's ALU port.
module tb_alu_mul_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_c;

    int vectors;
    int miscompares;

    alu_mul_seq #(.WIDTH(W), .ITER(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_c      (alu_c)
    );

    // Shared-ALU stand-in: only ADD produces a meaningful result.
    always_comb begin
        {alu_c, alu_result} = '0;
        if (alu_ctrl == 3'b000)
            {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Present a start pulse for exactly one edge; returns at the negedge after it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Called at the negedge after the accepting edge. Waits for done (bounded),
    // optionally spraying ignored starts while busy, then checks timing and product.
    task automatic wait_done(input string tag, input logic [63:0] exp, input bit noise);
        int  cycles;
        bit  ctrl_ok;
        bit  excl_ok;
        cycles  = 0;
        ctrl_ok = 1'b1;
        excl_ok = 1'b1;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && cycles < 40) begin
            if (noise && busy) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            @(negedge clk);
            cycles++;
            if (busy && alu_ctrl !== 3'b000) ctrl_ok = 1'b0;
            if (busy && done) excl_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cycles), 64'd32);
        check({tag, "_product"}, {product_hi, product_lo}, exp);
        check({tag, "_ctrl_excl"}, {62'd0, ctrl_ok, excl_ok}, 64'd3);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise);
        @(negedge clk);
        launch(a, b);
        wait_done(tag, ref_mul(a, b), noise);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [63:0]  held;
        bit           seen;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        check("reset_flags", {62'd0, busy, done}, 64'd0);
        check("reset_product", {product_hi, product_lo}, 64'd0);
        check("idle_alu", {alu_a, alu_b}, 64'd0);

        run_op("mul_3x5", 32'd3, 32'd5, 1'b0);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mul_max_const", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mul_zero", 32'd0, 32'h1234_5678, 1'b0);
        run_op("mul_msb", 32'h8000_0000, 32'd2, 1'b0);

        // Reset in the middle of RUN discards everything.
        @(negedge clk);
        launch(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_flags", {62'd0, busy, done}, 64'd0);
        check("midrst_product", {product_hi, product_lo}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midrst_quiet", 64'(seen), 64'd0);

        // Starts during RUN are ignored.
        run_op("noise_11x13", 32'd11, 32'd13, 1'b1);

        // Start held in the DONE cycle chains the next operation.
        run_op("b2b_first", 32'hDEAD_BEEF, 32'h0000_1001, 1'b0);
        check("b2b_done_seen", 64'(done), 64'd1);
        launch(32'h0BAD_F00D, 32'hCAFE_0001);
        wait_done("b2b_second", ref_mul(32'h0BAD_F00D, 32'hCAFE_0001), 1'b0);

        // Product holds while idle.
        run_op("hold_6x7", 32'd6, 32'd7, 1'b0);
        held = {product_hi, product_lo};
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done || {product_hi, product_lo} !== held) seen = 1'b1;
        end
        check("hold_stable", 64'(seen), 64'd0);
        check("hold_value", {product_hi, product_lo}, 64'd42);

        // Randomized operations, some with ignored-start noise, some chained.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if (i % 4 == 3) begin
                launch(ra, rb);
                wait_done("rand_chain", ref_mul(ra, rb), 1'b0);
            end else begin
                run_op("rand", ra, rb, bit'($urandom_range(0, 1)));
            end
        end

        repeat (2) @(negedge clk);
        check("final_idle", {62'd0, busy, done}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
